// File: rtl/mul_seq.sv
// Iterative RV32M multiplier (MUL/MULH/MULHSU/MULHU), radix-2 shift-add.
// All adds and sign-correction subtracts use the shared prefix adder through the add_* ports.
module mul_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             start_in,
  input  logic [1:0]       op_in,
  input  logic [WIDTH-1:0] rs1_in,
  input  logic [WIDTH-1:0] rs2_in,
  output logic             busy_out,
  output logic             done_out,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] add_a_out,
  output logic [WIDTH-1:0] add_b_out,
  output logic             add_cin_out,
  input  logic [WIDTH-1:0] add_sum_in,
  input  logic             add_cout_in
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [1:0] OP_MUL    = 2'b00;
  localparam logic [1:0] OP_MULH   = 2'b01;
  localparam logic [1:0] OP_MULHSU = 2'b10;
  localparam logic [1:0] OP_MULHU  = 2'b11;

  typedef enum logic [2:0] {IDLE, MUL, CORR_A, CORR_B, DONE} state_t;

  state_t           state;
  state_t           next_state;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] rs2_copy;
  logic [CW-1:0]    count;
  logic [1:0]       op;
  logic             last_step;

  assign last_step = (count == CW'(WIDTH - 1));

  always_ff @(posedge clk_in) begin
    if (rst_in) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE, DONE: next_state = start_in ? MUL : IDLE;
      MUL: begin
        if (last_step) begin
          unique case (op)
            OP_MULH:   next_state = CORR_A;
            OP_MULHSU: next_state = CORR_B;
            default:   next_state = DONE;
          endcase
        end
      end
      CORR_A:  next_state = CORR_B;
      CORR_B:  next_state = DONE;
      default: next_state = IDLE;
    endcase
  end

  // Corrections subtract via hi + ~x + 1; x is zero when the relevant sign bit is clear.
  always_comb begin
    busy_out    = 1'b0;
    done_out    = 1'b0;
    add_a_out   = '0;
    add_b_out   = '0;
    add_cin_out = 1'b0;
    unique case (state)
      MUL: begin
        busy_out  = 1'b1;
        add_a_out = hi;
        add_b_out = lo[0] ? mcand : '0;
      end
      CORR_A: begin
        busy_out    = 1'b1;
        add_a_out   = hi;
        add_b_out   = ~(mcand[WIDTH-1] ? rs2_copy : '0);
        add_cin_out = 1'b1;
      end
      CORR_B: begin
        busy_out    = 1'b1;
        add_a_out   = hi;
        add_b_out   = (op == OP_MULH) ? ~(rs2_copy[WIDTH-1] ? mcand : '0)
                                      : ~(mcand[WIDTH-1] ? rs2_copy : '0);
        add_cin_out = 1'b1;
      end
      DONE:    done_out = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      hi       <= '0;
      lo       <= '0;
      mcand    <= '0;
      rs2_copy <= '0;
      count    <= '0;
      op       <= '0;
      result   <= '0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (start_in) begin
            mcand    <= rs1_in;
            lo       <= rs2_in;
            rs2_copy <= rs2_in;
            hi       <= '0;
            count    <= '0;
            op       <= op_in;
          end
        end
        MUL: begin
          hi    <= {add_cout_in, add_sum_in[WIDTH-1:1]};
          lo    <= {add_sum_in[0], lo[WIDTH-1:1]};
          count <= count + CW'(1);
          // Unsigned ops finish here, so capture the product word on the way into DONE.
          if (last_step && op == OP_MUL)
            result <= {add_sum_in[0], lo[WIDTH-1:1]};
          else if (last_step && op == OP_MULHU)
            result <= {add_cout_in, add_sum_in[WIDTH-1:1]};
        end
        CORR_A: hi <= add_sum_in;
        CORR_B: begin
          hi     <= add_sum_in;
          result <= add_sum_in;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_seq.sv
// Self-checking bench for mul_seq: behavioural adder, scoreboard of expected products,
// latency/busy checks per operation, and protocol scenarios (ignored start, back-to-back, abort).
module tb_mul_seq;

  localparam logic [1:0] OP_MUL    = 2'b00;
  localparam logic [1:0] OP_MULH   = 2'b01;
  localparam logic [1:0] OP_MULHSU = 2'b10;
  localparam logic [1:0] OP_MULHU  = 2'b11;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        start_in;
  logic [1:0]  op_in;
  logic [31:0] rs1_in;
  logic [31:0] rs2_in;
  logic        busy_out;
  logic        done_out;
  logic [31:0] result;
  logic [31:0] add_a_out;
  logic [31:0] add_b_out;
  logic        add_cin_out;
  logic [31:0] add_sum_in;
  logic        add_cout_in;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_v;

  mul_seq #(.WIDTH(32)) dut (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .start_in    (start_in),
    .op_in       (op_in),
    .rs1_in      (rs1_in),
    .rs2_in      (rs2_in),
    .busy_out    (busy_out),
    .done_out    (done_out),
    .result      (result),
    .add_a_out   (add_a_out),
    .add_b_out   (add_b_out),
    .add_cin_out (add_cin_out),
    .add_sum_in  (add_sum_in),
    .add_cout_in (add_cout_in)
  );

  always #5 clk_in = ~clk_in;

  // Stand-in for the shared prefix adder.
  assign {add_cout_in, add_sum_in} = {1'b0, add_a_out} + {1'b0, add_b_out} + {32'b0, add_cin_out};

  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ea, eb, p;
    ea = (op == OP_MULH || op == OP_MULHSU) ? {{32{a[31]}}, a} : {32'b0, a};
    eb = (op == OP_MULH) ? {{32{b[31]}}, b} : {32'b0, b};
    p  = ea * eb;
    return (op == OP_MUL) ? p[31:0] : p[63:32];
  endfunction

  function automatic int latency(input logic [1:0] op);
    case (op)
      OP_MULH:   return 35;
      OP_MULHSU: return 34;
      default:   return 33;
    endcase
  endfunction

  // Scoreboard consumer: every done pulse pops and compares one expected result.
  always @(negedge clk_in) begin
    if (done_out === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_done result=%h expected no completion", result);
      end else begin
        exp_v = exp_q.pop_front();
        if (result !== exp_v) begin
          errors++;
          $display("[TB] FAIL result got=%h expected=%h", result, exp_v);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL global_timeout simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  // Called at a negedge: drive one start request and push its expected result.
  task automatic drive_start(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    start_in = 1'b1;
    op_in    = op;
    rs1_in   = a;
    rs2_in   = b;
    exp_q.push_back(model(op, a, b));
  endtask

  // Walks cycles T+1.. after a start; returns at the negedge of the DONE cycle.
  task automatic await_done(input int lat, input int ignore_at);
    bit seen = 1'b0;
    bit busy_bad = 1'b0;
    for (int k = 1; k <= lat + 3 && !seen; k++) begin
      @(negedge clk_in);
      if (k == 1) start_in = 1'b0;
      if (k == ignore_at) begin
        start_in = 1'b1;
        op_in    = OP_MULHU;
        rs1_in   = 32'd3;
        rs2_in   = 32'd9;
      end else if (k == ignore_at + 1) begin
        start_in = 1'b0;
      end
      if (done_out === 1'b1) begin
        seen = 1'b1;
        checks++;
        if (k != lat) begin
          errors++;
          $display("[TB] FAIL latency got=%0d expected=%0d", k, lat);
        end
        checks++;
        if (busy_out !== 1'b0) begin
          errors++;
          $display("[TB] FAIL busy_at_done got=%b expected=0", busy_out);
        end
      end else if (busy_out !== 1'b1) begin
        busy_bad = 1'b1;
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("[TB] FAIL done_timeout got=no_done expected=done within %0d cycles", lat + 3);
      start_in = 1'b0;
    end
    checks++;
    if (busy_bad) begin
      errors++;
      $display("[TB] FAIL busy_while_running got=0 expected=1");
    end
  endtask

  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] want;
    want = model(op, a, b);
    @(negedge clk_in);
    drive_start(op, a, b);
    await_done(latency(op), 0);
    @(negedge clk_in);
    checks++;
    if (result !== want || done_out !== 1'b0) begin
      errors++;
      $display("[TB] FAIL result_hold got=%h/done=%b expected=%h/done=0", result, done_out, want);
    end
  endtask

  task automatic test_reset();
    rst_in   = 1'b1;
    start_in = 1'b0;
    op_in    = 2'b00;
    rs1_in   = '0;
    rs2_in   = '0;
    repeat (2) @(negedge clk_in);
    checks++;
    if (busy_out !== 1'b0 || done_out !== 1'b0 || result !== 32'h0) begin
      errors++;
      $display("[TB] FAIL reset_outputs got busy=%b done=%b result=%h expected 0/0/0",
               busy_out, done_out, result);
    end
    checks++;
    if (add_a_out !== 32'h0 || add_b_out !== 32'h0 || add_cin_out !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_adder got a=%h b=%h cin=%b expected zeros",
               add_a_out, add_b_out, add_cin_out);
    end
    rst_in = 1'b0;
  endtask

  task automatic test_ops();
    run_op(OP_MUL,    32'd7,        32'd6);
    run_op(OP_MUL,    32'hFFFFFFFF, 32'hFFFFFFFF);
    run_op(OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF);
    run_op(OP_MULH,   32'hFFFFFFFF, 32'h00000002);
    run_op(OP_MULH,   32'h80000000, 32'h80000000);
    run_op(OP_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    run_op(OP_MULHSU, 32'h00001234, 32'h80000001);
    run_op(OP_MULH,   32'h7FFFFFFF, 32'h80000000);
    run_op(OP_MUL,    32'h0,        32'hDEADBEEF);
  endtask

  task automatic test_random();
    for (int i = 0; i < 8; i++)
      run_op(2'($urandom_range(0, 3)), $urandom, $urandom);
  endtask

  task automatic test_ignore_start();
    @(negedge clk_in);
    drive_start(OP_MUL, 32'd7, 32'd6);
    await_done(33, 5);
  endtask

  task automatic test_back_to_back();
    @(negedge clk_in);
    drive_start(OP_MULHU, 32'h12345678, 32'h9ABCDEF0);
    await_done(33, 0);
    drive_start(OP_MUL, 32'h0000FFFF, 32'h00010001);
    await_done(33, 0);
  endtask

  task automatic test_reset_abort();
    int dones = 0;
    @(negedge clk_in);
    drive_start(OP_MULH, 32'h80000000, 32'h00000003);
    void'(exp_q.pop_back());
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk_in);
      if (k == 1) start_in = 1'b0;
    end
    rst_in = 1'b1;
    @(negedge clk_in);
    checks++;
    if (busy_out !== 1'b0 || result !== 32'h0 || done_out !== 1'b0) begin
      errors++;
      $display("[TB] FAIL abort_state got busy=%b result=%h done=%b expected 0/0/0",
               busy_out, result, done_out);
    end
    rst_in = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk_in);
      if (done_out === 1'b1) dones++;
    end
    checks++;
    if (dones != 0) begin
      errors++;
      $display("[TB] FAIL abort_no_done got=%0d pulses expected=0", dones);
    end
  endtask

  initial begin
    test_reset();
    test_ops();
    test_random();
    test_ignore_start();
    test_back_to_back();
    test_reset_abort();
    @(negedge clk_in);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain got=%0d pending expected=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
